// File: rtl/tile_buffer8.sv
// Collects a raster-order pixel stream into an 8x8 tile and holds it for the
// downstream pooling stage, with start-of-tile resync and a handoff counter.
module tile_buffer8 #(
  parameter int BW = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BW-1:0]                in_data,
  input  logic                         in_sof,
  output logic [0:7][0:7][BW-1:0]      tile,
  output logic                         tile_valid,
  input  logic                         tile_ready,
  output logic                         sof_err,
  output logic [15:0]                  tile_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [5:0]                idx_q, idx_d;
  logic [0:7][0:7][BW-1:0]   tile_q, tile_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      xfer;

  // Handshake outputs are pure state decodes, forced low while reset is held.
  assign in_ready   = (state_q == FILL) && !rst;
  assign tile_valid = (state_q == FULL) && !rst;
  assign xfer       = in_valid && in_ready;

  assign tile     = tile_q;
  assign sof_err  = err_q;
  assign tile_cnt = cnt_q;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tile_d  = tile_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      FILL: begin
        if (xfer) begin
          if (in_sof && (idx_q != 6'd0)) begin
            // Resync: restart the tile at [0][0]; stale pixels get overwritten later.
            tile_d[0][0] = in_data;
            idx_d        = 6'd1;
            err_d        = 1'b1;
          end else begin
            tile_d[idx_q[5:3]][idx_q[2:0]] = in_data;
            idx_d = idx_q + 6'd1;
            if (idx_q == 6'd63) state_d = FULL;
          end
        end
      end
      FULL: begin
        if (tile_ready) begin
          state_d = FILL;
          cnt_d   = cnt_q + 16'd1;
        end
      end
    endcase
  end

  // NOTE: the tile array is reset explicitly because a cleared tile is visible
  // on the output port; a plain storage RAM would normally be left unreset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= 6'd0;
      tile_q  <= '0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tile_q  <= tile_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tile_buffer8.sv
// Self-checking bench for tile_buffer8: a behavioural model predicts handshake,
// flags and contents; completed tiles are queued and popped when tile_valid rises.
module tb_tile_buffer8;
  localparam int BW = 8;
  typedef logic [0:7][0:7][BW-1:0] tile_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          in_sof;
  tile_t         tile;
  logic          tile_valid;
  logic          tile_ready;
  logic          sof_err;
  logic [15:0]   tile_cnt;

  always #5 clk = ~clk;

  tile_buffer8 #(.BW(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .tile       (tile),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .sof_err    (sof_err),
    .tile_cnt   (tile_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  tile_t       m_tile;
  tile_t       hold;
  logic [5:0]  m_idx;
  logic        m_full;
  logic        m_err;
  logic [15:0] m_cnt;
  tile_t       sb_q[$];
  logic        tv_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tile  = '0;
    m_idx   = 6'd0;
    m_full  = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 16'd0;
    tv_prev = 1'b0;
    sb_q.delete();
  endtask

  task automatic observe();
    check("in_ready", 64'(in_ready), 64'(!m_full));
    check("tile_valid", 64'(tile_valid), 64'(m_full));
    check("sof_err", 64'(sof_err), 64'(m_err));
    check("tile_cnt", 64'(tile_cnt), 64'(m_cnt));
    for (int r = 0; r < 8; r++)
      check($sformatf("row%0d", r), 64'(tile[r]), 64'(m_tile[r]));
    if (tile_valid && !tv_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_tile", 64'd1, 64'd0);
      end else begin
        hold = sb_q.pop_front();
        for (int r = 0; r < 8; r++)
          check($sformatf("sb_row%0d", r), 64'(tile[r]), 64'(hold[r]));
      end
    end
    tv_prev = tile_valid;
  endtask

  // Drive one cycle, advance the model on the edge, check 1 ns after it.
  task automatic step(input logic v, input logic [BW-1:0] d, input logic s, input logic tr);
    in_valid   = v;
    in_data    = d;
    in_sof     = s;
    tile_ready = tr;
    @(posedge clk);
    if (m_full) begin
      if (tr) begin
        m_full = 1'b0;
        m_cnt  = m_cnt + 16'd1;
      end
    end else if (v) begin
      if (s && (m_idx != 6'd0)) begin
        m_tile[0][0] = d;
        m_idx        = 6'd1;
        m_err        = 1'b1;
      end else begin
        m_tile[m_idx[5:3]][m_idx[2:0]] = d;
        if (m_idx == 6'd63) begin
          m_full = 1'b1;
          sb_q.push_back(m_tile);
        end
        m_idx = m_idx + 6'd1;
      end
    end
    #1;
    observe();
  endtask

  task automatic fill(input int n, input int base, input logic sof_first);
    for (int i = 0; i < n; i++)
      step(1'b1, BW'(base + i), sof_first && (i == 0), 1'b0);
  endtask

  task automatic handoff();
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; tile_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_tile_valid", 64'(tile_valid), 64'd0);
    check("rst_tile_cnt", 64'(tile_cnt), 64'd0);
    #2 rst = 1'b0;

    // Basic fill: value == raster index, tile_valid the cycle after pixel 63.
    fill(64, 0, 1'b1);
    check("basic_r7c7", 64'(tile[7][7]), 64'd63);
    check("basic_r2c5", 64'(tile[2][5]), 64'd21);

    // Backpressure: input activity while FULL must be ignored.
    for (int i = 0; i < 10; i++)
      step(1'b1, BW'($urandom_range(0, 255)), 1'b0, 1'b0);
    check("bp_cnt_held", 64'(tile_cnt), 64'd0);
    handoff();
    check("bp_cnt_one", 64'(tile_cnt), 64'd1);
    check("bp_ready_back", 64'(in_ready), 64'd1);

    // Bubbles: valid every other cycle, 64 transfers over 128 cycles.
    begin
      int n = 0;
      for (int k = 0; k < 128; k++) begin
        step(k % 2 == 0, BW'(n), (k == 0), 1'b0);
        if (k % 2 == 0) n++;
        if (k == 125) check("bub_not_yet", 64'(tile_valid), 64'd0);
        if (k == 126) check("bub_full", 64'(tile_valid), 64'd1);
      end
    end
    check("bub_r4c3", 64'(tile[4][3]), 64'd35);
    handoff();

    // Mid-tile resync after 20 pixels.
    fill(20, 8'h01, 1'b1);
    check("rs_no_err_yet", 64'(sof_err), 64'd0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("rs_err", 64'(sof_err), 64'd1);
    check("rs_r0c0", 64'(tile[0][0]), 64'hAA);
    fill(63, 8'h40, 1'b0);
    check("rs_full", 64'(tile_valid), 64'd1);
    handoff();
    fill(64, 8'h80, 1'b1);
    check("rs_err_sticky", 64'(sof_err), 64'd1);
    handoff();

    // in_sof on the 64th pixel restarts the tile instead of completing it.
    fill(63, 8'h10, 1'b1);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("sof63_stay_fill", 64'(tile_valid), 64'd0);
    check("sof63_idx", 64'(dut.idx_q), 64'd1);
    fill(63, 8'h20, 1'b0);
    handoff();

    // Asynchronous reset between edges after 30 pixels.
    fill(30, 8'h60, 1'b1);
    rst = 1'b1;
    #2;
    check("arst_in_ready", 64'(in_ready), 64'd0);
    check("arst_tile_valid", 64'(tile_valid), 64'd0);
    check("arst_sof_err", 64'(sof_err), 64'd0);
    check("arst_idx", 64'(dut.idx_q), 64'd0);
    check("arst_cnt", 64'(tile_cnt), 64'd0);
    for (int r = 0; r < 8; r++)
      check($sformatf("arst_row%0d", r), 64'(tile[r]), 64'd0);
    model_reset();
    #2 rst = 1'b0;
    fill(64, 8'h03, 1'b1);
    check("arst_refill_full", 64'(tile_valid), 64'd1);
    handoff();
    check("arst_cnt_one", 64'(tile_cnt), 64'd1);

    // Counter wrap: preload 0xFFFF while filling, then one more handoff.
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFF;
    fill(64, 8'h07, 1'b1);
    check("wrap_pre", 64'(tile_cnt), 64'hFFFF);
    handoff();
    check("wrap_zero", 64'(tile_cnt), 64'h0000);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_buffer8.md
TILE_BUFFER8 -- requirements
Module: tile_buffer8

Interface
REQ-001 SHALL have parameter BW, default 8, pixel bit width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream pixel valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a pixel this cycle.
REQ-006 SHALL have port in_data  input  BW  pixel value, raster order (row-major, col 0..7).
REQ-007 SHALL have port in_sof  input  1  start-of-tile marker, qualified by in_valid && in_ready.
REQ-008 SHALL have port tile  output  BW x [0:7][0:7]  assembled 8x8 tile, feeds the 2x2 pooling stage's pool_in.
REQ-009 SHALL have port tile_valid  output  1  tile holds a complete, stable 8x8 tile.
REQ-010 SHALL have port tile_ready  input  1  downstream consumes tile.
REQ-011 SHALL have port sof_err  output  1  sticky flag: in_sof seen mid-tile.
REQ-012 SHALL have port tile_cnt  output  16  number of tiles handed off, wraps 0xFFFF -> 0x0000.

Function
REQ-013 SHALL implement a two-state FSM: FILL (accepting pixels) and FULL (holding tile).
REQ-014 SHALL drive in_ready = 1 in FILL, 0 in FULL; in_ready is a pure decode of state.
REQ-015 SHALL drive tile_valid = 1 in FULL, 0 in FILL; decode of state, no extra register stage.
REQ-016 SHALL define a pixel transfer as in_valid && in_ready on a rising edge; no other cycle writes the tile array.
REQ-017 SHALL keep a 6-bit index idx; transfer writes in_data to tile[idx[5:3]][idx[2:0]].
REQ-018 SHALL increment idx by 1 per transfer; transfer at idx==63 sets idx to 0 and state to FULL on the same edge.
REQ-019 SHALL, so tile_valid rises the cycle after the 64th transfer (latency 1 cycle from last pixel).
REQ-020 SHALL hold tile, idx and state unchanged in FULL until tile_ready == 1 is sampled.
REQ-021 SHALL, on tile_ready == 1 in FULL, return to FILL and increment tile_cnt by 1; in_ready rises the next cycle.
REQ-022 SHALL ignore tile_ready in FILL and ignore in_valid/in_data/in_sof in FULL.
REQ-023 SHALL, on a transfer with in_sof == 1 and idx == 0, proceed normally (no error).
REQ-024 SHALL, on a transfer with in_sof == 1 and idx != 0, write the pixel to tile[0][0], set idx to 1, and set sof_err = 1.
REQ-025 SHALL not clear pixels left from the aborted partial tile; they are overwritten by subsequent transfers.
REQ-026 SHALL keep sof_err set until reset; no other clear.
REQ-027 SHALL give in_sof no effect at idx == 63 other than REQ-024 (resync wins over tile completion; state stays FILL).
REQ-028 SHALL keep tile contents unchanged in FILL except at the indexed location, so tile reflects a partially overwritten previous tile while tile_valid == 0.

Reset
REQ-029 SHALL, while rst == 1, asynchronously force state FILL, idx 0, every tile element 0, tile_cnt 0, sof_err 0.
REQ-030 SHALL drive in_ready = 0 and tile_valid = 0 while rst == 1, regardless of state.
REQ-031 SHALL, on rst asserted mid-fill or in FULL, discard the partial/held tile without incrementing tile_cnt.
REQ-032 SHALL accept the first transfer on the first rising edge after rst deasserts, with in_valid == 1.

Verification
REQ-033 SHALL test basic fill: 64 pixels in_data = index 0..63, in_valid held, in_sof on first -> tile[r][c] == 8r+c, tile_valid rises cycle after pixel 63, in_ready == 0 next.
REQ-034 SHALL test backpressure: hold tile_ready = 0 for 10 cycles in FULL with in_valid = 1 and changing in_data -> tile unchanged, tile_cnt unchanged; tile_ready = 1 -> tile_cnt == 1, in_ready == 1 next cycle.
REQ-035 SHALL test bubbles: in_valid toggling 1/0 every cycle -> tile_valid after exactly 64 transfers (128 cycles); contents 8r+c.
REQ-036 SHALL test mid-tile resync: 20 pixels, then in_sof with value 0xAA -> sof_err == 1, tile[0][0] == 0xAA, 63 more pixels complete the tile; sof_err stays 1 through next tile.
REQ-037 SHALL test async reset: assert rst between edges after 30 pixels -> in_ready, tile_valid, tile, idx, sof_err all 0 immediately; next full tile completes in 64 transfers.
REQ-038 SHALL test counter wrap: preload via 65536 handoffs (or force) -> tile_cnt reads 0x0000 after the 65536th.
